// File: rtl/mac_pkg.sv
// Shared sizing constants and the tree-width helper for the MAC reduction datapath.
// No logic, no latency; consumed at elaboration only.
// No flow control of its own.
package mac_pkg;

    localparam int BW_DEF     = 8;
    localparam int PR_DEF     = 16;
    localparam int PSUM_W_DEF = 32;

    // Full-precision width of the tree sum: one product plus one bit per tree level.
    function automatic int tw_calc(input int bw, input int pr);
        return 2 * bw + 1 + $clog2(pr);
    endfunction

endpackage

// File: rtl/mac_add_tree.sv
// Pipelined pairwise reduction of N signed lanes, carrying valid/last/is_signed tags alongside.
// Latency: log2(N) cycles, one registered level per tree level.
// Backpressure: en low freezes every level and every tag; nothing is dropped.
module mac_add_tree
    import mac_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int N     = 16,
    parameter int OUT_W = IN_W + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_vld,
    input  logic                    in_last,
    input  logic                    in_sgn,
    input  logic [N*IN_W-1:0]       in_dat,
    output logic                    out_vld,
    output logic                    out_last,
    output logic                    out_sgn,
    output logic signed [OUT_W-1:0] out_dat
);

    localparam int LV = $clog2(N);

    // Every level is held at the final width; upper bits of early levels are pure sign copies.
    logic signed [OUT_W-1:0] sum_q [LV][N];
    logic signed [OUT_W-1:0] sum_d [LV][N];
    logic [LV-1:0]           vld_q, vld_d;
    logic [LV-1:0]           last_q, last_d;
    logic [LV-1:0]           sgn_q, sgn_d;

    always_comb begin
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < N; i++) begin
                sum_d[l][i] = sum_q[l][i];
            end
        end
        vld_d  = vld_q;
        last_d = last_q;
        sgn_d  = sgn_q;
        if (en) begin
            for (int i = 0; i < N / 2; i++) begin
                sum_d[0][i] = OUT_W'($signed(in_dat[(2*i)*IN_W +: IN_W]))
                            + OUT_W'($signed(in_dat[(2*i+1)*IN_W +: IN_W]));
            end
            for (int l = 1; l < LV; l++) begin
                for (int i = 0; i < N / 2; i++) begin
                    if (i < (N >> (l + 1))) begin
                        sum_d[l][i] = sum_q[l-1][2*i] + sum_q[l-1][2*i+1];
                    end
                end
            end
            vld_d  = (vld_q  << 1) | LV'(in_vld);
            last_d = (last_q << 1) | LV'(in_last);
            sgn_d  = (sgn_q  << 1) | LV'(in_sgn);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '{default: '0};
            vld_q  <= '0;
            last_q <= '0;
            sgn_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            vld_q  <= vld_d;
            last_q <= last_d;
            sgn_q  <= sgn_d;
        end
    end

    assign out_dat  = sum_q[LV-1][0];
    assign out_vld  = vld_q[LV-1];
    assign out_last = last_q[LV-1];
    assign out_sgn  = sgn_q[LV-1];

endmodule

// File: rtl/mac_tree_acc.sv
// PR-lane dot-product accumulator: input reg, product reg, log2(PR) tree levels, accumulate/output reg.
// Latency: log2(PR)+2 cycles from accepting a last beat to out_valid; MAC_TREE_SAT_EN selects saturation over wrap.
// Backpressure: out_valid && !out_ready stalls the whole pipe and drops in_ready; no beat lost or repeated.
module mac_tree_acc
    import mac_pkg::*;
#(
    parameter int BW     = BW_DEF,
    parameter int PR     = PR_DEF,
    parameter int PSUM_W = PSUM_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PR*BW-1:0]         a,
    input  logic [PR*BW-1:0]         b,
    input  logic                     is_signed,
    input  logic                     last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [PSUM_W-1:0] out
);

    localparam int TW = tw_calc(BW, PR);
    localparam int PW = 2 * BW + 1;

    logic adv;

    logic [PR*BW-1:0] a_q, a_d, b_q, b_d;
    logic             s0_vld_q, s0_vld_d, s0_sgn_q, s0_sgn_d, s0_last_q, s0_last_d;

    logic [PR*PW-1:0] prod_q, prod_d;
    logic             s1_vld_q, s1_vld_d, s1_sgn_q, s1_sgn_d, s1_last_q, s1_last_d;

    logic                 tree_vld, tree_last, tree_sgn_unused;
    logic signed [TW-1:0] tree_sum;

    logic signed [PSUM_W-1:0] sum_ext, acc_base, acc_next;
    logic signed [PSUM_W-1:0] acc_q, acc_d, out_q, out_d;
    logic                     first_q, first_d, out_valid_q, out_valid_d;

    assign adv       = !(out_valid_q && !out_ready);
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    // Input capture keeps the multipliers fed from flops rather than from the upstream port.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        s0_vld_d  = s0_vld_q;
        s0_sgn_d  = s0_sgn_q;
        s0_last_d = s0_last_q;
        if (adv) begin
            s0_vld_d = in_valid;
            if (in_valid) begin
                a_d       = a;
                b_d       = b;
                s0_sgn_d  = is_signed;
                s0_last_d = last;
            end
        end
    end

    always_comb begin
        logic signed [BW:0] ea;
        logic signed [BW:0] eb;
        ea        = '0;
        eb        = '0;
        prod_d    = prod_q;
        s1_vld_d  = s1_vld_q;
        s1_sgn_d  = s1_sgn_q;
        s1_last_d = s1_last_q;
        if (adv) begin
            for (int i = 0; i < PR; i++) begin
                ea = $signed({s0_sgn_q & a_q[i*BW+BW-1], a_q[i*BW +: BW]});
                eb = $signed({s0_sgn_q & b_q[i*BW+BW-1], b_q[i*BW +: BW]});
                prod_d[i*PW +: PW] = PW'(ea * eb);
            end
            s1_vld_d  = s0_vld_q;
            s1_sgn_d  = s0_sgn_q;
            s1_last_d = s0_last_q;
        end
    end

    mac_add_tree #(
        .IN_W  (PW),
        .N     (PR),
        .OUT_W (TW)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .in_vld   (s1_vld_q),
        .in_last  (s1_last_q),
        .in_sgn   (s1_sgn_q),
        .in_dat   (prod_q),
        .out_vld  (tree_vld),
        .out_last (tree_last),
        .out_sgn  (tree_sgn_unused),
        .out_dat  (tree_sum)
    );

    assign sum_ext  = PSUM_W'(tree_sum);
    assign acc_base = first_q ? '0 : acc_q;

`ifdef MAC_TREE_SAT_EN
    localparam logic signed [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    logic signed [PSUM_W:0] acc_wide;

    // One guard bit is enough: both addends already lie inside the PSUM_W range.
    always_comb begin
        acc_wide = (PSUM_W+1)'(acc_base) + (PSUM_W+1)'(sum_ext);
        if (acc_wide[PSUM_W] != acc_wide[PSUM_W-1]) begin
            acc_next = acc_wide[PSUM_W] ? SAT_MIN : SAT_MAX;
        end else begin
            acc_next = acc_wide[PSUM_W-1:0];
        end
    end
`else
    assign acc_next = acc_base + sum_ext;
`endif

    always_comb begin
        acc_d       = acc_q;
        first_d     = first_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (tree_vld) begin
                if (tree_last) begin
                    out_d       = acc_next;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    first_d     = 1'b1;
                end else begin
                    acc_d   = acc_next;
                    first_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            s0_vld_q    <= 1'b0;
            s0_sgn_q    <= 1'b0;
            s0_last_q   <= 1'b0;
            prod_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            s0_vld_q    <= s0_vld_d;
            s0_sgn_q    <= s0_sgn_d;
            s0_last_q   <= s0_last_d;
            prod_q      <= prod_d;
            s1_vld_q    <= s1_vld_d;
            s1_sgn_q    <= s1_sgn_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/mac_tree_acc.md
MAC_TREE_ACC -- requirements
Module: mac_tree_acc

Interface
REQ-001 SHALL have parameter BW, default 8: operand width per lane.
REQ-002 SHALL have parameter PR, default 16: lane count; power of two, at least 2.
REQ-003 SHALL have parameter PSUM_W, default 32: accumulator/output width; must be at least TW = 2*BW+1+log2(PR).
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block accepts a beat.
REQ-008 a, b  in  PR*BW  packed operands; lane i occupies bits [BW*(i+1)-1 : BW*i].
REQ-009 is_signed  in  1  1 = lanes are two's complement; 0 = lanes are unsigned. Sampled per beat.
REQ-010 last  in  1  marks the final beat of an accumulation group.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out  out  PSUM_W  signed accumulated dot product.

Function
REQ-014 A beat SHALL be accepted when in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-015 Stage S1 SHALL register PR products, each computed at 2*BW+1 bits signed (unsigned operands zero-extended, signed operands sign-extended).
REQ-016 The adder tree SHALL register one pipeline level per tree level: log2(PR) levels, final width TW, all sign-extended.
REQ-017 The accumulate stage SHALL compute acc_next = (first beat of group ? 0 : acc) + sign-extended tree sum.
REQ-018 When the last beat of a group reaches the accumulate stage, out SHALL take acc_next, out_valid SHALL assert, and acc SHALL clear.
REQ-019 Latency from the accepting edge of a last beat to out_valid high SHALL be log2(PR)+2 cycles (6 for PR=16).
REQ-020 With out_valid && !out_ready, the whole pipeline SHALL stall: valid, is_signed and last tags, acc and out held, with no beat lost or duplicated.
REQ-021 out_valid SHALL deassert on out_ready unless a new result completes in the same cycle.
REQ-022 Non-last beats SHALL never assert out_valid.
REQ-023 A group of one beat (last on the first beat) SHALL output that beat's sum alone.
REQ-024 Bubbles (in_valid low) SHALL propagate as invalid stages and SHALL NOT modify acc.

Reset
REQ-025 rst SHALL clear all stage valids, the acc value, the first-beat flag (set to 1), out to 0 and out_valid to 0, independent of clk.
REQ-026 Reset mid-group SHALL discard the partial group; the next accepted beat starts a new group.
REQ-027 in_ready SHALL be 1 during and after reset.

Configuration
REQ-028 Macro MAC_TREE_SAT_EN defined: the accumulate stage SHALL saturate to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
REQ-029 Macro MAC_TREE_SAT_EN undefined: the accumulate stage SHALL wrap modulo 2^PSUM_W, with no saturation logic.

Structure
REQ-030 Package mac_pkg SHALL hold the default BW/PR/PSUM_W constants and a function computing TW from BW and PR.
REQ-031 One sub-module, mac_add_tree (parametrised pipelined reduction tree carrying valid/last/is_signed tags with a stall enable), SHALL be instantiated once.

Verification (PR=16, BW=8, PSUM_W=32 unless stated)
REQ-032 Bench: all lanes a=1, b=1, is_signed=1, last=1 -> out=16 exactly 6 cycles after acceptance.
REQ-033 Bench: all lanes a=-128, b=-128, signed, last -> out=262144; unsigned a=255, b=255 -> out=1040400.
REQ-034 Bench: three beats of a=b=1, last on the third, with one bubble between beats -> a single out_valid with out=48.
REQ-035 Bench: out_ready=0 for 4 cycles while 3 groups stream -> in_ready low, out held stable, all 3 results delivered in order after release.
REQ-036 Bench: PSUM_W=21, two unsigned beats of 255*255, last on the second -> out=1048575 with MAC_TREE_SAT_EN, -16352 without.
REQ-037 Bench: assert rst after 2 beats of an open group, then send one beat a=b=1 with last -> out=16.
